// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with a per-digit modulus, parallel load,
// wrap/saturate boundary handling and a registered terminal-count pulse.
module bcd_updown_counter #(
  parameter int                      NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0] DIGIT_MOD  = 16'h6A6A,
  parameter bit                      WRAP       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    dir_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] load_val_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic                    tc_o,
  output logic                    zero_o,
  output logic                    max_o
);

  localparam int W = 4*NUM_DIGITS;

  logic [W-1:0]          digits_q, digits_d;
  logic [W-1:0]          load_clamped;
  logic                  tc_q, tc_d;
  logic [NUM_DIGITS-1:0] at_max, at_zero;
  logic [NUM_DIGITS-1:0] up_step, dn_step;
  logic                  all_max, all_zero;

  function automatic logic [3:0] mod_m1(input int idx);
    return DIGIT_MOD[4*idx +: 4] - 4'd1;
  endfunction

  // Per-digit decode plus the ripple of "all lower digits at max/zero".
  always_comb begin
    logic up_c;
    logic dn_c;
    up_c         = 1'b1;
    dn_c         = 1'b1;
    at_max       = '0;
    at_zero      = '0;
    up_step      = '0;
    dn_step      = '0;
    load_clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      at_max[i]  = (digits_q[4*i +: 4] == mod_m1(i));
      at_zero[i] = (digits_q[4*i +: 4] == 4'd0);
      up_step[i] = up_c;
      dn_step[i] = dn_c;
      up_c       = up_c & at_max[i];
      dn_c       = dn_c & at_zero[i];
      load_clamped[4*i +: 4] = (load_val_i[4*i +: 4] >= DIGIT_MOD[4*i +: 4]) ?
                               mod_m1(i) : load_val_i[4*i +: 4];
    end
    all_max  = up_c;
    all_zero = dn_c;
  end

  always_comb begin
    digits_d = digits_q;
    tc_d     = 1'b0;
    if (load_i) begin
      digits_d = load_clamped;
    end else if (en_i) begin
      if (!dir_i) begin
        tc_d = all_max;
        // Saturation at the top simply suppresses the step.
        if (WRAP || !all_max) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (up_step[i]) begin
              digits_d[4*i +: 4] = at_max[i] ? 4'd0 : digits_q[4*i +: 4] + 4'd1;
            end
          end
        end
      end else begin
        tc_d = all_zero;
        if (WRAP || !all_zero) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dn_step[i]) begin
              digits_d[4*i +: 4] = at_zero[i] ? mod_m1(i) : digits_q[4*i +: 4] - 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      digits_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      digits_q <= digits_d;
      tc_q     <= tc_d;
    end
  end

  assign digits_o = digits_q;
  assign tc_o     = tc_q;
  assign zero_o   = all_zero;
  assign max_o    = all_max;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: wrap and saturate instances driven in lockstep,
// checked against a mixed-radix integer model of the count.
module tb_bcd_updown_counter;

  localparam logic [15:0] MODS  = 16'h6A6A;
  localparam int          TOTAL = 10*6*10*6;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0, en_i = 1'b0, dir_i = 1'b0, load_i = 1'b0;
  logic [15:0] load_val_i = '0;
  logic [15:0] dig_w, dig_s;
  logic        tc_w, tc_s, zero_w, zero_s, max_w, max_s;

  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  idx_w = 0, idx_s = 0;
  bit  mtc_w = 1'b0, mtc_s = 1'b0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.NUM_DIGITS(4), .DIGIT_MOD(MODS), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst_i(rst_i), .en_i(en_i), .dir_i(dir_i), .load_i(load_i),
    .load_val_i(load_val_i), .digits_o(dig_w), .tc_o(tc_w), .zero_o(zero_w), .max_o(max_w));

  bcd_updown_counter #(.NUM_DIGITS(4), .DIGIT_MOD(MODS), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst_i(rst_i), .en_i(en_i), .dir_i(dir_i), .load_i(load_i),
    .load_val_i(load_val_i), .digits_o(dig_s), .tc_o(tc_s), .zero_o(zero_s), .max_o(max_s));

  function automatic int mod_of(input int i);
    logic [15:0] m;
    m = MODS;
    return int'(m[4*i +: 4]);
  endfunction

  // Digits as a mixed-radix number: digit 0 is least significant.
  function automatic int to_idx(input logic [15:0] d);
    int idx, w, v, m;
    idx = 0;
    w   = 1;
    for (int i = 0; i < 4; i++) begin
      m = mod_of(i);
      v = int'(d[4*i +: 4]);
      if (v >= m) v = m - 1;
      idx += v * w;
      w   *= m;
    end
    return idx;
  endfunction

  function automatic logic [15:0] to_dig(input int idx);
    logic [15:0] d;
    int r;
    d = '0;
    r = idx;
    for (int i = 0; i < 4; i++) begin
      d[4*i +: 4] = 4'(r % mod_of(i));
      r = r / mod_of(i);
    end
    return d;
  endfunction

  task automatic model_one(inout int idx, output bit tc, input bit wrap);
    tc = 1'b0;
    if (rst_i) idx = 0;
    else if (load_i) idx = to_idx(load_val_i);
    else if (en_i) begin
      if (!dir_i) begin
        if (idx == TOTAL-1) begin tc = 1'b1; if (wrap) idx = 0; end
        else idx = idx + 1;
      end else begin
        if (idx == 0) begin tc = 1'b1; if (wrap) idx = TOTAL-1; end
        else idx = idx - 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":wrap.digits"}, 32'(dig_w), 32'(to_dig(idx_w)));
    chk({tag, ":wrap.tc"},     32'(tc_w),   32'(mtc_w));
    chk({tag, ":wrap.zero"},   32'(zero_w), 32'(idx_w == 0));
    chk({tag, ":wrap.max"},    32'(max_w),  32'(idx_w == TOTAL-1));
    chk({tag, ":sat.digits"},  32'(dig_s),  32'(to_dig(idx_s)));
    chk({tag, ":sat.tc"},      32'(tc_s),   32'(mtc_s));
    chk({tag, ":sat.zero"},    32'(zero_s), 32'(idx_s == 0));
    chk({tag, ":sat.max"},     32'(max_s),  32'(idx_s == TOTAL-1));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_one(idx_w, mtc_w, 1'b1);
    model_one(idx_s, mtc_s, 1'b0);
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset, then count up through a tens/minutes carry.
    rst_i = 1'b1;
    step("reset");
    chk("reset.digits", 32'(dig_w), 32'h0);
    chk("reset.zero",   32'(zero_w), 32'h1);
    rst_i = 1'b0; en_i = 1'b1; dir_i = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      step("count_up");
      if (k == 59) chk("up.0059", 32'(dig_w), 32'h0059);
    end
    chk("up.0100", 32'(dig_w), 32'h0100);

    // Top wrap on the WRAP=1 instance, saturate on the other.
    en_i = 1'b0; load_i = 1'b1; load_val_i = 16'h5959;
    step("load_5959");
    load_i = 1'b0; en_i = 1'b1;
    step("top_wrap");
    chk("top_wrap.digits", 32'(dig_w), 32'h0);
    chk("top_wrap.tc",     32'(tc_w),  32'h1);
    chk("top_sat.digits",  32'(dig_s), 32'h5959);
    en_i = 1'b0;
    step("top_wrap_after");
    chk("top_wrap.tc_one_cycle", 32'(tc_w), 32'h0);

    // Down from zero: saturated instance pulses tc every step.
    rst_i = 1'b1;
    step("reset2");
    rst_i = 1'b0; en_i = 1'b1; dir_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step("sat_down");
      chk("sat_down.digits", 32'(dig_s), 32'h0);
      chk("sat_down.tc",     32'(tc_s),  32'h1);
    end

    // Borrow across a zero digit.
    en_i = 1'b0; load_i = 1'b1; load_val_i = 16'h1000;
    step("load_1000");
    load_i = 1'b0; en_i = 1'b1; dir_i = 1'b1;
    step("borrow");
    chk("borrow.0959", 32'(dig_w), 32'h0959);
    for (int k = 0; k < 10; k++) step("borrow_more");
    chk("borrow.0949", 32'(dig_w), 32'h0949);

    // Load clamp wins over a simultaneous count enable.
    load_i = 1'b1; load_val_i = 16'h7A9F; en_i = 1'b1; dir_i = 1'b0;
    step("load_clamp");
    chk("clamp.digits", 32'(dig_w), 32'h5959);
    chk("clamp.max",    32'(max_w), 32'h1);
    chk("clamp.tc",     32'(tc_w),  32'h0);

    // Reset while counting.
    load_val_i = 16'h0122;
    step("load_0122");
    load_i = 1'b0;
    step("to_0123");
    chk("mid.0123", 32'(dig_w), 32'h0123);
    rst_i = 1'b1;
    step("mid_reset");
    chk("mid_reset.digits", 32'(dig_w), 32'h0);
    rst_i = 1'b0;
    step("after_reset");
    chk("after_reset.digits", 32'(dig_w), 32'h0001);
    chk("after_reset.tc",     32'(tc_w),  32'h0);

    // Random traffic, biased towards the boundaries.
    for (int k = 0; k < 600; k++) begin
      rst_i  = ($urandom_range(0, 63) == 0);
      load_i = ($urandom_range(0, 7) == 0);
      en_i   = ($urandom_range(0, 3) != 0);
      dir_i  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: load_val_i = 16'h5959;
        1: load_val_i = 16'h0000;
        2: load_val_i = 16'h5958;
        3: load_val_i = 16'h0001;
        default: load_val_i = 16'($urandom);
      endcase
      step("random");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
